out_port_tx: RTL

Downstream consumer of the CPU's `cpu_out` port (register 15). It watches `cpu_out` for value changes and queues each new value in a small FIFO. It then serialises each queued byte as a UART 8N1 frame on `tx`, so program results can be read by a host or a bench monitor without probing internal registers. It sits beside `cpu` at top level and shares its clock and reset.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/out_port_tx_if.sv | 26 ++
 rtl/out_fifo.sv | 52 +++++
 rtl/out_port_tx.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and widths shared by the CPU datapath and its output-port consumers.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/out_port_tx_if.sv
// Bundle between the CPU output register and the UART serialiser.
interface out_port_tx_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] cpu_out;
    logic              enable;
    logic              tx;
    logic              busy;
    logic              overflow;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output cpu_out, enable,
        input  tx, busy, overflow, fifo_count
    );

    modport slave (
        input  cpu_out, enable,
        output tx, busy, overflow, fifo_count
    );

endinterface

// File: rtl/out_fifo.sv
// Small synchronous FIFO; head entry is readable combinationally on dout.
module out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// Captures changes on the CPU output register, queues them, and sends each
// queued byte as a UART 8N1 frame on tx.
module out_port_tx
    import cpu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic         CLK,
    input  logic         reset,
    out_port_tx_if.slave bus
);
    localparam int unsigned         CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned         BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_dout;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              capture_c;
    logic              pop_c;
    logic              tx_q;
    logic              busy_q;
    logic              overflow_q;

    assign capture_c = bus.enable && (bus.cpu_out != prev);
    assign pop_c     = (state == TX_IDLE) && !fifo_empty;

    out_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (capture_c),
        .pop   (pop_c),
        .din   (bus.cpu_out),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A capture that finds the FIFO full is lost even if a pop frees a slot.
    always_ff @(posedge CLK) begin
        if (reset) begin
            prev       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.enable)              prev       <= bus.cpu_out;
            if (capture_c && fifo_full)  overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= TX_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            shreg   <= '0;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop_c) begin
                        shreg   <= fifo_dout;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        tx_q  <= shreg[0];
                        state <= TX_DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud   <= '0;
                        busy_q <= 1'b0;
                        state  <= TX_IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = fifo_count;

endmodule
